fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall_i  input  1  hold PC and IF/ID register.
REQ-006 redirect_i  input  1  taken branch/jump (pc_src from control unit).
REQ-007 redirect_target_i  input  32  branch/JAL/JALR target address.
REQ-008 imem_rdata_i  input  32  instruction word at imem_addr_o, valid same cycle.
REQ-009 imem_addr_o  output  32  instruction memory fetch address (current PC).
REQ-010 instr_o  output  32  IF/ID registered instruction.
REQ-011 pc_o  output  32  IF/ID registered PC of instr_o.
REQ-012 pc_plus4_o  output  32  IF/ID registered PC+4 (JAL/JALR link value).
REQ-013 valid_o  output  1  instr_o is a real fetched instruction.
REQ-014 opcode_o / funct3_o / funct7_o  output  7/3/7  instr_o[6:0], instr_o[14:12], instr_o[31:25], combinational slices feeding the control unit.
REQ-015 misalign_o  output  1  one-cycle pulse: redirect target had bit 1 set.
REQ-016 stall_cnt_o  output  32  count of cycles with stall_i high and redirect_i low.

Function
REQ-017 imem_addr_o SHALL equal the PC register continuously (no added latency).
REQ-018 Normal cycle (stall_i=0, redirect_i=0): PC <= PC+4; instr_o <= imem_rdata_i; pc_o <= PC; pc_plus4_o <= PC+4; valid_o <= 1.
REQ-019 PC+4 SHALL be 32-bit modular; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-020 Redirect (redirect_i=1): PC <= {redirect_target_i[31:2],2'b00}; IF/ID flushed: instr_o <= NOP_INSTR, valid_o <= 0, pc_o/pc_plus4_o <= 0.
REQ-021 Bit 0 of redirect_target_i SHALL be ignored (JALR clear rule); if bit 1 is set, misalign_o SHALL be 1 in the cycle after the redirect edge, else 0.
REQ-022 Redirect SHALL take priority over stall_i when both are high in the same cycle.
REQ-023 Stall (stall_i=1, redirect_i=0): PC, instr_o, pc_o, pc_plus4_o, valid_o hold; stall_cnt_o increments by 1.
REQ-024 stall_cnt_o SHALL wrap 32'hFFFF_FFFF -> 0; it SHALL NOT increment on redirect or normal cycles.
REQ-025 misalign_o SHALL be 0 in every cycle not immediately following a misaligned redirect.
REQ-026 Two consecutive redirects SHALL each flush; valid_o stays 0 until one normal cycle elapses.
REQ-027 Following a redirect, the first normal cycle SHALL capture the instruction at the new PC with valid_o=1.

Reset
REQ-028 When rst_n=0 at a rising edge: PC <= RESET_PC; instr_o <= NOP_INSTR; pc_o <= 0; pc_plus4_o <= 0; valid_o <= 0; misalign_o <= 0; stall_cnt_o <= 0.
REQ-029 Reset SHALL override stall_i and redirect_i; asserting rst_n=0 mid-stall or mid-redirect yields the REQ-028 state at the next edge.
REQ-030 First fetch after reset release SHALL present imem_addr_o=RESET_PC; first valid instr_o appears one edge later.

Verification
REQ-031 Reset, then 3 normal cycles with imem returning 32'h00500093, 32'h00A00113, 32'h002081B3 -> imem_addr_o 0,4,8,12; instr_o sequence matches; pc_o 0,4,8; valid_o=1 after first edge.
REQ-032 At PC=8 assert redirect_i with target 32'h0000_0041 -> next PC 32'h40, instr_o=32'h00000013, valid_o=0, misalign_o=0; next cycle valid_o=1, pc_o=32'h40.
REQ-033 Redirect target 32'h0000_0106 -> PC 32'h104, misalign_o=1 for exactly one cycle.
REQ-034 Hold stall_i=1 for 5 cycles at PC=12 -> PC, instr_o, valid_o unchanged; stall_cnt_o=5; stall_i=1 with redirect_i=1 -> redirect taken, stall_cnt_o stays 5.
REQ-035 Force PC to 32'hFFFF_FFFC via redirect, then one normal cycle -> imem_addr_o=0, pc_o=32'hFFFF_FFFC, pc_plus4_o=0.
REQ-036 Drive rst_n=0 for one edge during a stall with stall_cnt_o=7 -> all outputs at REQ-028 values, imem_addr_o=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect/flush
// handling, misaligned-target pulse and a free-running stall-cycle counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] imem_addr_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic        misalign_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect wins over stall; bit 0 of the target is dropped, bit 1 only flags.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    valid_d     = valid_q;
    misalign_d  = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (redirect_i) begin
      pc_d       = {redirect_target_i[31:2], 2'b00};
      instr_d    = NOP_INSTR;
      id_pc_d    = 32'd0;
      id_pc4_d   = 32'd0;
      valid_d    = 1'b0;
      misalign_d = redirect_target_i[1];
    end else if (stall_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      pc_d     = pc_plus4;
      instr_d  = imem_rdata_i;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = id_pc_q;
  assign pc_plus4_o  = id_pc4_q;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;
  assign stall_cnt_o = stall_cnt_q;
  assign opcode_o    = instr_q[6:0];
  assign funct3_o    = instr_q[14:12];
  assign funct7_o    = instr_q[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the documented scenarios,
// then random traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, redirect_i;
  logic [31:0] redirect_target_i, imem_rdata_i;
  logic [31:0] imem_addr_o, instr_o, pc_o, pc_plus4_o, stall_cnt_o;
  logic        valid_o, misalign_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  funct3_o;

  int tests = 0;
  int failed = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_target_i(redirect_target_i), .imem_rdata_i(imem_rdata_i),
    .imem_addr_o(imem_addr_o), .instr_o(instr_o), .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o), .valid_o(valid_o), .opcode_o(opcode_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o), .misalign_o(misalign_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, stall, redir;
    logic [31:0] tgt, rdata;
    logic [31:0] e_addr, e_instr, e_pc, e_pc4;
    logic        e_valid, e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [31:0] ea, ei, ep, ep4,
                           input logic ev, em, input logic [31:0] ec);
    chk("imem_addr", idx, imem_addr_o, ea);
    chk("instr", idx, instr_o, ei);
    chk("pc", idx, pc_o, ep);
    chk("pc_plus4", idx, pc_plus4_o, ep4);
    chk("valid", idx, {31'd0, valid_o}, {31'd0, ev});
    chk("misalign", idx, {31'd0, misalign_o}, {31'd0, em});
    chk("stall_cnt", idx, stall_cnt_o, ec);
    chk("decode_fields", idx, {15'd0, funct7_o, funct3_o, opcode_o},
        {15'd0, ei[31:25], ei[14:12], ei[6:0]});
  endtask

  task automatic drive(input logic r, s, d, input logic [31:0] t, rd);
    @(negedge clk);
    rst_n = r; stall_i = s; redirect_i = d; redirect_target_i = t; imem_rdata_i = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, s, d, logic [31:0] t, rd, ea, ei, ep, ep4,
                              logic ev, em, logic [31:0] ec);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redir = d; v.tgt = t; v.rdata = rd;
    v.e_addr = ea; v.e_instr = ei; v.e_pc = ep; v.e_pc4 = ep4;
    v.e_valid = ev; v.e_mis = em; v.e_cnt = ec;
    return v;
  endfunction

  // Reference model state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
  logic        m_valid, m_mis;

  task automatic model_step(input logic r, s, d, input logic [31:0] t, rd);
    if (!r) begin
      m_pc = 32'd0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    end else if (d) begin
      m_pc = (t / 4) * 4; m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
      m_mis = ((t / 2) % 2) == 1;
    end else if (s) begin
      m_cnt = m_cnt + 1; m_mis = 0;
    end else begin
      m_ipc = m_pc; m_instr = rd; m_pc = m_pc + 4; m_ipc4 = m_pc; m_valid = 1; m_mis = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_target_i = 0; imem_rdata_i = 0;

    //          rst s  d  tgt           rdata         addr          instr         pc            pc4           v  m  cnt
    vecs[0]  = mk(0, 0, 0, 32'h0,        32'h0,        32'h0,        NOP,          32'h0,        32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        32'h00500093, 32'h4,        32'h00500093, 32'h0,        32'h4,        1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 32'h0,        32'h00A00113, 32'h8,        32'h00A00113, 32'h4,        32'h8,        1, 0, 0);
    vecs[3]  = mk(1, 0, 0, 32'h0,        32'h002081B3, 32'hC,        32'h002081B3, 32'h8,        32'hC,        1, 0, 0);
    for (int i = 0; i < 5; i++)
      vecs[4+i] = mk(1, 1, 0, 32'h0,     32'hDEADBEEF, 32'hC,        32'h002081B3, 32'h8,        32'hC,        1, 0, 32'(i+1));
    vecs[9]  = mk(1, 1, 1, 32'h41,       32'hDEADBEEF, 32'h40,       NOP,          32'h0,        32'h0,        0, 0, 5);
    vecs[10] = mk(1, 0, 0, 32'h0,        32'h11111111, 32'h44,       32'h11111111, 32'h40,       32'h44,       1, 0, 5);
    vecs[11] = mk(1, 0, 1, 32'h106,      32'h0,        32'h104,      NOP,          32'h0,        32'h0,        0, 1, 5);
    vecs[12] = mk(1, 0, 0, 32'h0,        32'h22222222, 32'h108,      32'h22222222, 32'h104,      32'h108,      1, 0, 5);
    vecs[13] = mk(1, 0, 1, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFC, NOP,          32'h0,        32'h0,        0, 1, 5);
    vecs[14] = mk(1, 0, 1, 32'hFFFFFFFD, 32'h0,        32'hFFFFFFFC, NOP,          32'h0,        32'h0,        0, 0, 5);
    vecs[15] = mk(1, 0, 0, 32'h0,        32'h33333333, 32'h0,        32'h33333333, 32'hFFFFFFFC, 32'h0,        1, 0, 5);
    vecs[16] = mk(1, 1, 0, 32'h0,        32'h0,        32'h0,        32'h33333333, 32'hFFFFFFFC, 32'h0,        1, 0, 6);
    vecs[17] = mk(1, 1, 0, 32'h0,        32'h0,        32'h0,        32'h33333333, 32'hFFFFFFFC, 32'h0,        1, 0, 7);
    vecs[18] = mk(0, 1, 0, 32'h0,        32'h0,        32'h0,        NOP,          32'h0,        32'h0,        0, 0, 0);
    vecs[19] = mk(0, 0, 1, 32'h86,       32'h0,        32'h0,        NOP,          32'h0,        32'h0,        0, 0, 0);
    vecs[20] = mk(1, 0, 0, 32'h0,        32'h44444444, 32'h4,        32'h44444444, 32'h0,        32'h4,        1, 0, 0);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].redir, vecs[i].tgt, vecs[i].rdata);
      check_all(i, vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc4,
                vecs[i].e_valid, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // Combinational fetch address follows the PC while inputs change mid-cycle.
    @(negedge clk);
    rst_n = 1; stall_i = 0; redirect_i = 1; redirect_target_i = 32'h300; imem_rdata_i = 0;
    #1;
    chk("imem_addr_no_latency", 100, imem_addr_o, 32'h4);
    @(posedge clk); #1;
    chk("imem_addr_after_redirect", 101, imem_addr_o, 32'h300);

    // Random phase, model starts from a reset edge.
    model_step(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check_all(200, m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_mis, m_cnt);
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, d;
      logic [31:0] t, rd;
      r  = ($urandom_range(0, 39) != 0);
      s  = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 4) == 0);
      t  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rd = $urandom;
      model_step(r, s, d, t, rd);
      drive(r, s, d, t, rd);
      check_all(300 + i, m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_mis, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
